// File: rtl/servo_slew_controller.sv
// Servo slew controller: accepts clamped target positions and ramps the PWM
// duty word toward them by a bounded step, at most once per PWM frame.
module servo_slew_controller #(
    parameter int unsigned FRAME_CYCLES = 500000,
    parameter int unsigned DUTY_MIN     = 26,
    parameter int unsigned DUTY_MAX     = 128,
    parameter int unsigned DUTY_INIT    = 77
) (
    input  logic       clk25mhz,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_target,
    input  logic [3:0] cmd_step,
    input  logic       hold,
    output logic [9:0] duty_cycle,
    output logic       frame_tick,
    output logic       busy,
    output logic       at_target,
    output logic       cmd_clamped
);

    localparam int unsigned DUTY_W = 10;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned DIFF_W = 11;
    localparam int unsigned CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [DUTY_W-1:0] MIN_W    = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] MAX_W    = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_W   = DUTY_W'(DUTY_INIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DUTY_W-1:0]   duty_d;
    logic [DUTY_W-1:0]   clamped_target;
    logic                out_of_range;
    logic [DIFF_W-1:0]   diff;
    logic [DUTY_W-1:0]   stepped;
    logic                accept;
    logic                clamp_d;

    // Free-running frame counter; wraps at FRAME_CYCLES-1
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Saturate incoming target into the safe servo window
    always_comb begin
        clamped_target = cmd_target;
        out_of_range   = 1'b0;
        if (cmd_target < MIN_W) begin
            clamped_target = MIN_W;
            out_of_range   = 1'b1;
        end else if (cmd_target > MAX_W) begin
            clamped_target = MAX_W;
            out_of_range   = 1'b1;
        end
    end

    // Candidate duty word for one frame of slewing toward the latched target
    always_comb begin
        if (target_q >= duty_cycle) begin
            diff = {1'b0, target_q} - {1'b0, duty_cycle};
        end else begin
            diff = {1'b0, duty_cycle} - {1'b0, target_q};
        end
        if ((step_q == '0) || (diff <= DIFF_W'(step_q))) begin
            stepped = target_q;
        end else if (target_q > duty_cycle) begin
            stepped = duty_cycle + DUTY_W'(step_q);
        end else begin
            stepped = duty_cycle - DUTY_W'(step_q);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_cycle;
        target_d = target_q;
        step_d   = step_q;
        clamp_d  = 1'b0;
        accept   = cmd_valid & cmd_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (target_q == duty_cycle) ? IDLE : RAMP;
            end
            RAMP: begin
                // A step on the same edge as an accept still uses the old target
                if (frame_tick && !hold) begin
                    duty_d = stepped;
                    if (stepped == target_q) begin
                        state_d = IDLE;
                    end
                end
                if (accept) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            target_d = clamped_target;
            step_d   = cmd_step;
            clamp_d  = out_of_range;
        end
    end

    // State register
    always_ff @(posedge clk25mhz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk25mhz or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            frame_tick  <= 1'b0;
            duty_cycle  <= INIT_W;
            target_q    <= INIT_W;
            step_q      <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            at_target   <= 1'b1;
            cmd_clamped <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_tick  <= (cnt_d == CNT_LAST);
            duty_cycle  <= duty_d;
            target_q    <= target_d;
            step_q      <= step_d;
            cmd_ready   <= (state_d != LOAD);
            busy        <= (state_d != IDLE);
            at_target   <= (duty_d == target_d);
            cmd_clamped <= clamp_d;
        end
    end

endmodule

// File: doc/servo_slew_controller.md
Name: servo_slew_controller

Overview:
- Upstream stage of the servo PWM driver; produces the 10-bit duty_cycle word that the driver serialises into the 20 ms servo waveform.
- Accepts target positions from the reg_io command path via a valid/ready handshake and clamps each target to safe servo limits.
- Ramps the duty word toward the target by a programmable step, at most once per PWM frame, so the PWM never sees a mid-frame change and the servo never slews faster than commanded.

Parameters:
- FRAME_CYCLES, 500000, clk25mhz cycles per PWM frame (20 ms at 25 MHz); benches override with a small value.
- DUTY_MIN, 26, lowest legal duty word (~0.5 ms pulse).
- DUTY_MAX, 128, highest legal duty word (~2.5 ms pulse).
- DUTY_INIT, 77, duty word after reset (~1.5 ms, centre).

Ports:
- clk25mhz  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_target  in  10  requested duty word
- cmd_step  in  4  max change per frame; 0 = jump directly to target
- hold  in  1  freeze ramping while high
- duty_cycle  out  10  duty word to the PWM driver
- frame_tick  out  1  one-cycle pulse at end of each frame
- busy  out  1  command loading or ramp in progress
- at_target  out  1  duty_cycle equals latched target
- cmd_clamped  out  1  one-cycle pulse: last accepted target was clamped

Behaviour:
- Reset (reset low, asynchronous):
  - duty_cycle=DUTY_INIT, target_r=DUTY_INIT, step_r=0.
  - Frame counter=0, state=IDLE.
  - cmd_ready=1, busy=0, at_target=1, frame_tick=0, cmd_clamped=0.
- Frame counter:
  - Free-runs 0..FRAME_CYCLES-1, then wraps to 0.
  - frame_tick is registered, high for exactly the one cycle in which the counter holds FRAME_CYCLES-1.
  - Unaffected by commands or hold.
- States: IDLE, LOAD, RAMP. cmd_ready=1 in IDLE and RAMP, 0 in LOAD.
- Accept occurs when cmd_valid & cmd_ready at a rising edge. On accept:
  - target_r <= clamp(cmd_target, DUTY_MIN, DUTY_MAX); step_r <= cmd_step.
  - State -> LOAD.
  - cmd_clamped asserts in the LOAD cycle iff cmd_target<DUTY_MIN or cmd_target>DUTY_MAX.
- LOAD (exactly 1 cycle):
  - -> IDLE if target_r==duty_cycle, else -> RAMP.
  - No duty update in LOAD; a frame_tick coinciding with LOAD is consumed without stepping.
- RAMP: on a cycle with frame_tick=1 and hold=0:
  - step_r==0: duty_cycle <= target_r.
  - |target_r-duty_cycle| <= step_r: duty_cycle <= target_r.
  - otherwise: duty_cycle moves toward target_r by step_r.
  - State -> IDLE when the new duty_cycle equals target_r (same edge).
- Difference arithmetic is 11-bit unsigned compare of max-min. No overflow is possible because both operands are within [DUTY_MIN, DUTY_MAX].
- A new command accepted during RAMP overrides the old target; the ramp continues from the current duty_cycle with no jump.
- If a frame_tick and an accept land on the same edge in RAMP, the step is applied using the old target, then LOAD is entered.
- hold=1: no duty updates; commands are still accepted; frame counter runs. Ramping resumes at the first frame_tick after hold drops.
- duty_cycle changes only on frame_tick edges or reset; at most one change per frame.
- Outputs:
  - busy = (state!=IDLE).
  - at_target = (duty_cycle==target_r), registered view consistent with state.
- Reset asserted mid-ramp immediately restores all reset values; any in-flight command is dropped.

Test Plan (FRAME_CYCLES=10):
- Release reset, idle 50 cycles -> duty_cycle=77 throughout, frame_tick every 10 cycles, busy=0, at_target=1, cmd_ready=1.
- Command target=100 step=5 -> LOAD one cycle (cmd_ready=0), then duty 82,87,92,97,100 on successive frame_ticks; busy drops on the edge reaching 100.
- Command target=1000 step=0 -> cmd_clamped pulse, duty jumps to 128 at next frame_tick; target=3 -> clamps to 26.
- Ramp 77->120 step=2, assert hold for 3 frames after 2 steps -> duty frozen at 81 for 3 ticks, then resumes 83,85,...
- Mid-ramp (duty=90, rising) new target=60 step=10 -> duty 80,70,60 with no jump; frame_tick coinciding with accept steps on the old target first.
- Assert reset mid-ramp -> duty_cycle=77, state IDLE, counter 0 asynchronously; the next command behaves as after power-up.
